// File: rtl/alu_complete_unit.sv
// ALU completion stage: executes issued ops, queues results, drains to writeback.
// Optional feature: define ALU_MINMAX_EN to enable MIN/MAX/MINU/MAXU on opcodes 11-14.
package alu_complete_unit_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  dest;
    logic [4:0]  rob;
  } wb_entry_t;
endpackage

module alu_complete_unit #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        flush_i,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  alu_opc,
  input  logic [4:0]  alu_rob_id,
  input  logic [5:0]  alu_dest,
  input  logic        alu_valid,
  output logic        alu_busy_o,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_data_o,
  output logic [5:0]  wb_dest_o,
  output logic [4:0]  wb_rob_o,
  output logic        overflow_o
);
  import alu_complete_unit_pkg::*;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      result;
  wb_entry_t        mem [FIFO_DEPTH];
  wb_entry_t        head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Combinational ALU datapath
  always_comb begin
    result = '0;
    case (alu_opc)
      4'd0:  result = alu_a + alu_b;
      4'd1:  result = alu_a - alu_b;
      4'd2:  result = alu_a << alu_b[4:0];
      4'd3:  result = 32'($signed(alu_a) < $signed(alu_b));
      4'd4:  result = 32'(alu_a < alu_b);
      4'd5:  result = alu_a ^ alu_b;
      4'd6:  result = alu_a >> alu_b[4:0];
      4'd7:  result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd8:  result = alu_a | alu_b;
      4'd9:  result = alu_a & alu_b;
      4'd10: result = alu_b;
`ifdef ALU_MINMAX_EN
      4'd11: result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
      4'd12: result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      4'd13: result = (alu_a < alu_b) ? alu_a : alu_b;
      4'd14: result = (alu_a > alu_b) ? alu_a : alu_b;
`endif
      default: result = '0;
    endcase
  end

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign wb_valid_o = (count != '0);
  assign pop        = wb_valid_o & wb_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push       = alu_valid & ~flush_i & (~full | pop);
  assign drop       = alu_valid & ~flush_i & full & ~pop;
  assign alu_busy_o = (count >= CNT_W'(FIFO_DEPTH - 2));

  assign head      = wb_valid_o ? mem[rd_ptr] : '0;
  assign wb_data_o = head.data;
  assign wb_dest_o = head.dest;
  assign wb_rob_o  = head.rob;

  always_ff @(posedge cpu_clock_i) begin
    if (push) begin
      mem[wr_ptr] <= '{data: result, dest: alu_dest, rob: alu_rob_id};
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_complete_unit.sv
// Directed self-checking bench for alu_complete_unit (honours ALU_MINMAX_EN if defined).
module tb_alu_complete_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  opc = '0;
  logic [4:0]  rob = '0;
  logic [5:0]  dest = '0;
  logic        valid = 1'b0;
  logic        busy;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [5:0]  wb_dest;
  logic [4:0]  wb_rob;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  alu_complete_unit #(.FIFO_DEPTH(4)) dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush),
    .alu_a(a), .alu_b(b), .alu_opc(opc), .alu_rob_id(rob), .alu_dest(dest),
    .alu_valid(valid), .alu_busy_o(busy), .wb_valid_o(wb_valid),
    .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_dest_o(wb_dest),
    .wb_rob_o(wb_rob), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive one bundle for a single cycle, then drop valid
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [5:0] d);
    opc = o; a = x; b = y; rob = r; dest = d; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", wb_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_cmp++; if ({wb_data, wb_dest, wb_rob} !== 43'h0) begin
      n_err++; $display("FAIL reset_head got %h/%h/%h want 0", wb_data, wb_dest, wb_rob); end
  endtask

  task automatic test_add();
    wb_ready = 1'b1;
    issue(4'd0, 32'd7, 32'd5, 5'd3, 6'd9);
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", wb_valid); end
    n_cmp++; if (wb_data !== 32'd12) begin n_err++; $display("FAIL add_data got %h want c", wb_data); end
    n_cmp++; if (wb_rob !== 5'd3) begin n_err++; $display("FAIL add_rob got %0d want 3", wb_rob); end
    n_cmp++; if (wb_dest !== 6'd9) begin n_err++; $display("FAIL add_dest got %0d want 9", wb_dest); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL add_drain got %b want 0", wb_valid); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL add_empty_data got %h want 0", wb_data); end
  endtask

  // Back-to-back ops with ready=1: each new push coincides with the previous pop
  task automatic test_ops();
    logic [3:0]  t_opc [13];
    logic [31:0] t_a [13];
    logic [31:0] t_b [13];
    logic [31:0] t_exp [13];
    t_opc[0]  = 4'd0;  t_a[0]  = 32'hFFFF_FFFF; t_b[0]  = 32'd2;        t_exp[0]  = 32'h1;
    t_opc[1]  = 4'd1;  t_a[1]  = 32'd0;         t_b[1]  = 32'd1;        t_exp[1]  = 32'hFFFF_FFFF;
    t_opc[2]  = 4'd2;  t_a[2]  = 32'd1;         t_b[2]  = 32'h3F;       t_exp[2]  = 32'h8000_0000;
    t_opc[3]  = 4'd3;  t_a[3]  = 32'hFFFF_FFFF; t_b[3]  = 32'd3;        t_exp[3]  = 32'h1;
    t_opc[4]  = 4'd4;  t_a[4]  = 32'd1;         t_b[4]  = 32'hFFFF_FFFF; t_exp[4] = 32'h1;
    t_opc[5]  = 4'd5;  t_a[5]  = 32'hF0F0_F0F0; t_b[5]  = 32'hFF00_FF00; t_exp[5] = 32'h0FF0_0FF0;
    t_opc[6]  = 4'd6;  t_a[6]  = 32'h8000_0000; t_b[6]  = 32'd4;        t_exp[6]  = 32'h0800_0000;
    t_opc[7]  = 4'd7;  t_a[7]  = 32'h8000_0000; t_b[7]  = 32'd4;        t_exp[7]  = 32'hF800_0000;
    t_opc[8]  = 4'd8;  t_a[8]  = 32'h0000_00F0; t_b[8]  = 32'h0000_000F; t_exp[8] = 32'h0000_00FF;
    t_opc[9]  = 4'd9;  t_a[9]  = 32'hF0F0_F0F0; t_b[9]  = 32'hFF00_FF00; t_exp[9] = 32'hF000_F000;
    t_opc[10] = 4'd10; t_a[10] = 32'd1;         t_b[10] = 32'hDEAD_BEEF; t_exp[10] = 32'hDEAD_BEEF;
`ifdef ALU_MINMAX_EN
    t_opc[11] = 4'd11; t_a[11] = 32'hFFFF_FFFE; t_b[11] = 32'd3;        t_exp[11] = 32'hFFFF_FFFE;
`else
    t_opc[11] = 4'd11; t_a[11] = 32'hFFFF_FFFE; t_b[11] = 32'd3;        t_exp[11] = 32'h0;
`endif
    t_opc[12] = 4'd15; t_a[12] = 32'd5;         t_b[12] = 32'd6;        t_exp[12] = 32'h0;
    wb_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      opc = t_opc[i]; a = t_a[i]; b = t_b[i]; rob = 5'(i); dest = 6'(i + 20); valid = 1'b1;
      tick();
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_data !== t_exp[i] || wb_rob !== 5'(i) || wb_dest !== 6'(i + 20)) begin
        n_err++;
        $display("FAIL op%0d_opc%0d got v=%b d=%h r=%0d t=%0d want v=1 d=%h r=%0d t=%0d",
                 i, t_opc[i], wb_valid, wb_data, wb_rob, wb_dest, t_exp[i], i, i + 20);
      end
    end
    valid = 1'b0;
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL ops_drain got %b want 0", wb_valid); end
  endtask

  task automatic test_overflow();
    wb_ready = 1'b0;
    issue(4'd10, 32'd0, 32'd101, 5'd1, 6'd1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy1 got %b want 0", busy); end
    issue(4'd10, 32'd0, 32'd102, 5'd2, 6'd2);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovf_busy2 got %b want 1", busy); end
    issue(4'd10, 32'd0, 32'd103, 5'd3, 6'd3);
    issue(4'd10, 32'd0, 32'd104, 5'd4, 6'd4);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
    issue(4'd10, 32'd0, 32'd105, 5'd5, 6'd5);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_data !== 32'(101 + i) || wb_rob !== 5'(i + 1)) begin
        n_err++;
        $display("FAIL ovf_drain%0d got v=%b d=%0d r=%0d want v=1 d=%0d r=%0d",
                 i, wb_valid, wb_data, wb_rob, 101 + i, i + 1);
      end
      tick();
    end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b want 0", wb_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 0; i < 4; i++) issue(4'd10, 32'd0, 32'(201 + i), 5'(i), 6'(i));
    wb_ready = 1'b1;
    issue(4'd10, 32'd0, 32'd205, 5'd4, 6'd4);
    wb_ready = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pp_busy got %b want 1", busy); end
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_data !== 32'(202 + i)) begin
        n_err++; $display("FAIL pp_drain%0d got v=%b d=%0d want v=1 d=%0d", i, wb_valid, wb_data, 202 + i);
      end
      tick();
    end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL pp_empty got %b want 0", wb_valid); end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(4'd10, 32'd0, 32'(301 + i), 5'(i), 6'(i));
    flush = 1'b1;
    issue(4'd10, 32'd0, 32'd399, 5'd9, 6'd9);
    flush = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got %b want 0", wb_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fl_busy got %b want 0", busy); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL fl_data got %h want 0", wb_data); end
    wb_ready = 1'b1;
    issue(4'd10, 32'd0, 32'd400, 5'd7, 6'd7);
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'd400) begin
      n_err++; $display("FAIL fl_after got v=%b d=%0d want v=1 d=400", wb_valid, wb_data); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL fl_empty got %b want 0", wb_valid); end
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd1, 5'd1, 6'd1);
    issue(4'd0, 32'd2, 32'd2, 5'd2, 6'd2);
    do_reset();
    n_cmp++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmid got v=%b busy=%b want 0/0", wb_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_overflow();
    test_full_pushpop();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
